// File: rtl/tug_of_war_core.sv
// Two-player tug-of-war: a one-hot light walks between players; reaching your end scores a round.
// Optional CPU opponent for player 2 is built only when TUG_OF_WAR_CPU_PLAYER_EN is defined.
module tug_of_war_core #(
   parameter int unsigned N_LIGHTS = 9,
   parameter int unsigned SCORE_W  = 3,
   parameter int unsigned LFSR_W   = 10,
   parameter int unsigned TICK_W   = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                key_p1,
   input  logic                key_p2,
   input  logic                cpu_mode,
   input  logic [LFSR_W-2:0]   difficulty,
   input  logic                new_game,
   output logic [N_LIGHTS-1:0] leds,
   output logic [SCORE_W-1:0]  p1_score,
   output logic [SCORE_W-1:0]  p2_score,
   output logic                game_over,
   output logic                winner
);

   localparam int unsigned             CENTER    = N_LIGHTS / 2;
   localparam logic [N_LIGHTS-1:0]     CENTER_OH = N_LIGHTS'(1) << CENTER;
   localparam logic [SCORE_W-1:0]      SCORE_MAX = '1;
   localparam int unsigned             N_KEYS    = 3;

   // Key vector order: 0 = p1, 1 = p2, 2 = new_game
   logic [N_KEYS-1:0] key_raw_c;
   logic [N_KEYS-1:0] sync1, sync2, prev, armed;
   logic [1:0]        warm;
   logic              warm_done_c;
   logic [N_KEYS-1:0] pulse_c;

   assign key_raw_c   = {new_game, key_p2, key_p1};
   assign warm_done_c = (warm == 2'd2);
   assign pulse_c     = sync2 & ~prev & armed;

   // A key only arms once it has been seen released after reset, so a held key cannot fire.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
         armed <= '0;
         warm  <= '0;
      end else begin
         sync1 <= key_raw_c;
         sync2 <= sync1;
         prev  <= sync2;
         armed <= armed | ({N_KEYS{warm_done_c}} & ~sync2);
         if (!warm_done_c) warm <= warm + 2'd1;
      end
   end

   logic p1_pulse_c, p2_pulse_c, ng_pulse_c;
   assign p1_pulse_c = pulse_c[0];
   assign ng_pulse_c = pulse_c[2];

`ifdef TUG_OF_WAR_CPU_PLAYER_EN
   logic [LFSR_W-1:0] lfsr;
   logic [TICK_W-1:0] tick;
   logic              cpu_pulse_c;

   // XNOR LFSR starts from zero; all-ones is its only lock-up state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr <= '0;
         tick <= '0;
      end else begin
         lfsr <= {lfsr[LFSR_W-2:0], ~(lfsr[LFSR_W-1] ^ lfsr[LFSR_W-4])};
         tick <= tick + TICK_W'(1);
      end
   end

   assign cpu_pulse_c = cpu_mode & (&tick) & ({1'b0, difficulty} > lfsr);
   assign p2_pulse_c  = cpu_mode ? cpu_pulse_c : pulse_c[1];
`else
   logic unused_cpu_c;
   assign unused_cpu_c = ^{cpu_mode, difficulty};
   assign p2_pulse_c   = pulse_c[1];
`endif

   logic [N_LIGHTS-1:0] leds_d;
   logic [SCORE_W-1:0]  p1_d, p2_d;
   logic                go_d, win_d;

   // Playfield next state; new_game wins over any move, moves are frozen once the game is over.
   always_comb begin
      leds_d = leds;
      p1_d   = p1_score;
      p2_d   = p2_score;
      go_d   = game_over;
      win_d  = winner;
      if (ng_pulse_c) begin
         leds_d = CENTER_OH;
         p1_d   = '0;
         p2_d   = '0;
         go_d   = 1'b0;
         win_d  = 1'b0;
      end else if (!game_over && (p1_pulse_c ^ p2_pulse_c)) begin
         if (p1_pulse_c) begin
            if (leds[0]) begin
               leds_d = CENTER_OH;
               p1_d   = p1_score + SCORE_W'(1);
               if (p1_d == SCORE_MAX) begin
                  go_d  = 1'b1;
                  win_d = 1'b0;
               end
            end else begin
               leds_d = leds >> 1;
            end
         end else begin
            if (leds[N_LIGHTS-1]) begin
               leds_d = CENTER_OH;
               p2_d   = p2_score + SCORE_W'(1);
               if (p2_d == SCORE_MAX) begin
                  go_d  = 1'b1;
                  win_d = 1'b1;
               end
            end else begin
               leds_d = leds << 1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         leds      <= CENTER_OH;
         p1_score  <= '0;
         p2_score  <= '0;
         game_over <= 1'b0;
         winner    <= 1'b0;
      end else begin
         leds      <= leds_d;
         p1_score  <= p1_d;
         p2_score  <= p2_d;
         game_over <= go_d;
         winner    <= win_d;
      end
   end

endmodule

// File: doc/tug_of_war_core.md
TUG_OF_WAR_CORE -- requirements
Module: tug_of_war_core

Interface
REQ-001 SHALL have parameter N_LIGHTS, default 9, number of playfield lights (odd, >=3).
REQ-002 SHALL have parameter SCORE_W, default 3, width of each score counter.
REQ-003 SHALL have parameter LFSR_W, default 10, width of the CPU random source.
REQ-004 SHALL have parameter TICK_W, default 2, CPU decision interval of 2^TICK_W clocks.
REQ-005 SHALL have port clk, input, 1, the one clock; all state is updated on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port key_p1, input, 1, raw player-1 button, active high, moves light right (toward leds[0]).
REQ-008 SHALL have port key_p2, input, 1, raw player-2 button, active high, moves light left (toward leds[N_LIGHTS-1]).
REQ-009 SHALL have port cpu_mode, input, 1, 1 = player 2 driven by CPU, key_p2 ignored.
REQ-010 SHALL have port difficulty, input, LFSR_W-1, CPU aggressiveness.
REQ-011 SHALL have port new_game, input, 1, raw request to clear scores and restart.
REQ-012 SHALL have port leds, output, N_LIGHTS, one-hot light position.
REQ-013 SHALL have ports p1_score and p2_score, output, SCORE_W each, round-win counts.
REQ-014 SHALL have port game_over, output, 1, high once either score reaches 2^SCORE_W-1.
REQ-015 SHALL have port winner, output, 1, 0 = player 1, 1 = player 2; valid only while game_over.

Function
REQ-016 SHALL pass key_p1, key_p2 and new_game each through a 2-flop synchronizer followed by a rising-edge detector, giving one pulse per press regardless of hold length.
REQ-017 SHALL update leds on the 3rd rising clk edge after a raw key rises (2 sync stages + position register).
REQ-018 SHALL move the light one position per accepted pulse; a p1 pulse and a p2 pulse on the same cycle SHALL cancel (no move).
REQ-019 SHALL, when the light is at leds[0] and a sole p1 pulse occurs, increment p1_score and set the light to center (index N_LIGHTS/2) on the same edge; symmetric for p2 at leds[N_LIGHTS-1].
REQ-020 SHALL set game_over and winner on the same edge a score becomes 2^SCORE_W-1; scores never wrap.
REQ-021 SHALL ignore all key and CPU pulses while game_over=1 (leds, scores frozen).
REQ-022 SHALL, on a new_game pulse, clear both scores, clear game_over and winner, and center the light, taking priority over a simultaneous move on that cycle.
REQ-023 SHALL keep leds strictly one-hot at all times.

Reset
REQ-024 SHALL, while reset_n=0, asynchronously force leds to center one-hot, scores to 0, game_over=0, winner=0, synchronizers, edge detectors, tick counter and LFSR to 0.
REQ-025 SHALL, when reset_n is asserted mid-round or mid-press, discard the pending press; a key held across reset deassertion SHALL NOT generate a pulse until released and pressed again.

Configuration
REQ-026 SHALL compile the CPU opponent only when macro TUG_OF_WAR_CPU_PLAYER_EN is defined.
REQ-027 With TUG_OF_WAR_CPU_PLAYER_EN: LFSR_W-bit XNOR LFSR (default taps bits 10,7) advances every clock; a TICK_W counter wraps every 2^TICK_W clocks; on each wrap with cpu_mode=1, a p2 pulse is generated iff {1'b0,difficulty} > LFSR value; difficulty=0 never presses.
REQ-028 Without TUG_OF_WAR_CPU_PLAYER_EN: no LFSR or tick logic; cpu_mode and difficulty are ignored; player 2 is always key_p2.

Verification
REQ-029 Reset, then 4 p1 presses (no CPU): leds 9'b000010000 -> 9'b000000001; 5th press -> p1_score=1, leds=9'b000010000.
REQ-030 Hold key_p1 high 20 cycles after reset: exactly one move, leds=9'b000001000.
REQ-031 key_p1 and key_p2 rise on the same cycle: leds unchanged at center.
REQ-032 Seven p1 round wins (35 presses): p1_score=7, game_over=1, winner=0; further presses leave leds/scores unchanged; new_game press -> scores 0, game_over=0, leds center.
REQ-033 With macro defined, cpu_mode=1, difficulty=9'h1FF, no p1 presses: light reaches leds[8], p2_score increments; difficulty=0 for 1000 cycles: leds stay center.
REQ-034 reset_n pulsed low mid-round with p2_score=3 and light at leds[2]: all outputs return to reset values immediately, without waiting for a clk edge.
